vdp_cpu_port: RTL and testbench
===============================

# vdp_cpu_port

Parametrised CPU-side port of the video display processor: decodes the data and control I/O ports, holds the VDP register file, the VRAM address pointer with auto-increment, a read-ahead byte buffer and the status/interrupt flags. It sits between the Z80 I/O decode in the top level and the video renderer's VRAM port. It replaces ad-hoc top-level glue and adds the following:

- a VRAM request/acknowledge handshake
- true read-ahead semantics
- status read-clear
- address widths above 16 KB through an extension register

## Interface

- ADDR_W, 14, VRAM address width, 14..17.
- NUM_REGS, 8, number of write-only VDP registers, 8..64. Must be >= 15 when ADDR_W > 14.
- EXT_REG, 14, register index holding VRAM address bits [ADDR_W-1:14]. Used only when ADDR_W > 14.

Ports:
- clk  in  1  system clock (the CPU clock domain).
- rst_n  in  1  asynchronous active-low reset.
- cpu_wr  in  1  one-cycle write strobe, already qualified by the CPU clock edge.
- cpu_rd  in  1  one-cycle read strobe, same qualification as cpu_wr.
- cpu_sel  in  1  0 = data port (0x98), 1 = control port (0x99).
- cpu_din  in  8  CPU write data.
- cpu_dout  out  8  read data; combinational, valid in the cpu_rd cycle.
- cpu_busy  out  1  VRAM transaction outstanding.
- overrun  out  1  sticky: a data-port strobe arrived while busy.
- vram_req  out  1  VRAM request, held until ack.
- vram_we  out  1  1 = write, 0 = read.
- vram_addr  out  ADDR_W  VRAM address.
- vram_wdata  out  8  VRAM write data.
- vram_ack  in  1  one-cycle completion, arbitrary latency >= 1.
- vram_rdata  in  8  read data, valid with vram_ack.
- irq_set  in  1  frame-end pulse from the renderer.
- coll_set  in  1  sprite-collision pulse.
- fifth_set  in  1  fifth-sprite pulse.
- fifth_num  in  5  sprite number, sampled with fifth_set.
- regs  out  NUM_REGS*8  flat register file; register i occupies bits [8i+7:8i].
- n_int  out  1  active-low interrupt, equal to !(F & R1[5]).

## Operation

State:
- latch flag: second control byte expected.
- first byte register.
- address pointer A.
- read buffer B.
- status flags F, 5S, C, and fifth number N.
- FSM with states IDLE, WAIT_WR, WAIT_RD.

Control write (cpu_wr, cpu_sel = 1):
- Latch clear: store cpu_din as the first byte and set the latch.
- Latch set: clear the latch, then act on cpu_din[7:6]:
  - 10: write the first byte to register cpu_din[5:0]. Indices >= NUM_REGS are ignored.
  - 01: A = {ext bits, cpu_din[5:0], first byte}. No prefetch.
  - 00: load A the same way, then issue a prefetch read.
  - 11: treated as 10.
- Ext bits are regs[EXT_REG][ADDR_W-15:0]. They are zero-width when ADDR_W = 14.

Data write (cpu_sel = 0):
- Clear the latch.
- B <= cpu_din.
- Issue a VRAM write of cpu_din at A, then increment A.

Data read (cpu_sel = 0):
- Clear the latch.
- cpu_dout = B.
- Increment A, then issue a prefetch of the new A. The prefetched byte loads B on ack.

Status read (cpu_sel = 1):
- Clear the latch.
- cpu_dout = {F, 5S, C, 5S ? N : 5'b11111}.
- F, 5S and C clear on the next edge.

Flags:
- irq_set sets F, coll_set sets C, and fifth_set sets 5S and loads N.
- fifth_set is ignored while 5S is already set.
- Any set pulse in the same cycle as the clear wins: the flag stays 1.

Address increment:
- A wraps from 2^ADDR_W-1 to 0.
- When ADDR_W > 14, a carry out of bit 13 also increments regs[EXT_REG], within its ADDR_W-14 low bits.

FSM:
- IDLE -> WAIT_WR on a data write. In that cycle vram_req rises with we=1 and the address/data are latched.
- IDLE -> WAIT_RD on a prefetch. vram_req rises with we=0.
- WAIT_* -> IDLE on vram_ack. On WAIT_RD, vram_rdata loads B.
- cpu_busy = state != IDLE.

Strobes while busy:
- Data-port strobes are dropped and set overrun; overrun is cleared only by reset.
- Control-port strobes are always accepted. An address set while busy takes effect on A immediately; its prefetch is dropped and sets overrun.

Reset: all registers, A, B, latch, flags, N and overrun are 0; state is IDLE; vram_req = 0; n_int = 1; cpu_dout reflects B = 0.

## Timing

- Strobe at edge k: vram_req is high from edge k+1. A is incremented at edge k+1.
- vram_addr, vram_we and vram_wdata are stable while vram_req is high.
- vram_ack at edge m: vram_req low and B updated at edge m+1. The next request may start at m+1.
- Register write is visible on regs one edge after the second control strobe.
- n_int follows F and R1[5] with one register delay.
- Reset assertion mid-transaction drops vram_req asynchronously. A late ack after reset is ignored.

## Test plan

- Reset -> regs = 0, n_int = 1, vram_req = 0, cpu_busy = 0, overrun = 0.
- Control writes 0x07,0x81, then 0x1F,0x87 -> regs R1 = 0x07, R7 = 0x1F. Control writes 0x55,0x90 (R16, NUM_REGS = 8) -> no change.
- Address setup and data write:
  - Stimulus: set address 0x3FFF for write (0xFF,0x7F), then data write 0xAA.
  - Required: VRAM write addr 0x3FFF, data 0xAA, then A = 0x0000.
  - Then, with ADDR_W = 17 and R14 = 2: the same sequence -> A = 0x0C000.
- Read-ahead:
  - Stimulus: set address 0x0100 for read (0x00,0x01); VRAM returns 0x11 at 0x0100 and 0x22 at 0x0101.
  - Required: the first data read returns 0x11 and prefetches 0x0101; the second read returns 0x22.
- Status and interrupt:
  - Stimulus: R1 = 0x20, then irq_set.
  - Required: n_int = 0; status read returns 0x9F; n_int returns to 1.
  - Stimulus: irq_set in the same cycle as the status-read clear -> F stays 1.
- Busy and latch:
  - Stimulus: hold vram_ack off for 5 cycles and issue a second data write.
  - Required: it is dropped and overrun = 1.
  - Stimulus: first control byte, then a status read, then a control write.
  - Required: the control write is treated as a first byte.

Source files
------------

// File: rtl/vdp_cpu_port_if.sv
// ============================================================================
// Module : vdp_cpu_port_if
// Brief  : VRAM request/acknowledge port between the VDP CPU port and renderer
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface vdp_cpu_port_if #(
  parameter int ADDR_W = 14
) ();
  logic              vram_req;
  logic              vram_we;
  logic [ADDR_W-1:0] vram_addr;
  logic [7:0]        vram_wdata;
  logic              vram_ack;
  logic [7:0]        vram_rdata;

  modport master (
    output vram_req, vram_we, vram_addr, vram_wdata,
    input  vram_ack, vram_rdata
  );

  modport slave (
    input  vram_req, vram_we, vram_addr, vram_wdata,
    output vram_ack, vram_rdata
  );
endinterface

`default_nettype wire

// File: rtl/vdp_cpu_port.sv
// ============================================================================
// Module : vdp_cpu_port
// Brief  : VDP CPU-side port: I/O decode, register file, VRAM pointer with
//          read-ahead buffer, status/interrupt flags and VRAM handshake
// Rev    : 1.0
// ============================================================================
`default_nettype none

module vdp_cpu_port #(
  parameter int ADDR_W   = 14,
  parameter int NUM_REGS = 8,
  parameter int EXT_REG  = 14
) (
  input  wire logic                  clk,
  input  wire logic                  rst_n,
  input  wire logic                  cpu_wr,
  input  wire logic                  cpu_rd,
  input  wire logic                  cpu_sel,
  input  wire logic [7:0]            cpu_din,
  output logic [7:0]                 cpu_dout,
  output logic                       cpu_busy,
  output logic                       overrun,
  vdp_cpu_port_if.master             vram,
  input  wire logic                  irq_set,
  input  wire logic                  coll_set,
  input  wire logic                  fifth_set,
  input  wire logic [4:0]            fifth_num,
  output logic [NUM_REGS*8-1:0]      regs,
  output logic                       n_int
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_WR = 2'd1,
    WAIT_RD = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_next;

  logic [7:0]         r_regs [NUM_REGS];
  logic               r_latch;
  logic [7:0]         r_first;
  logic [ADDR_W-1:0]  r_addr;
  logic [7:0]         r_buf;
  logic               r_f;
  logic               r_5s;
  logic               r_c;
  logic [4:0]         r_n;
  logic               r_overrun;
  logic               r_n_int;
  logic [ADDR_W-1:0]  r_vaddr;
  logic               r_we;
  logic [7:0]         r_wdata;

  logic               w_ctrl_wr;
  logic               w_data_wr;
  logic               w_data_rd;
  logic               w_stat_rd;
  logic               w_second;
  logic               w_reg_we;
  logic               w_reg_ok;
  logic               w_addr_set;
  logic               w_pf;
  logic               w_start_wr;
  logic               w_start_rd;
  logic               w_start_pf;
  logic               w_drop;
  logic               w_fifth_take;
  logic               w_ext_inc;
  logic               w_ext_bump;
  logic [7:0]         w_ext_next;
  logic [ADDR_W-1:0]  w_set_addr;
  logic [ADDR_W-1:0]  w_a_inc;

  assign w_ctrl_wr  = cpu_wr &  cpu_sel;
  assign w_data_wr  = cpu_wr & ~cpu_sel;
  assign w_data_rd  = cpu_rd & ~cpu_sel;
  assign w_stat_rd  = cpu_rd &  cpu_sel;
  assign w_second   = w_ctrl_wr & r_latch;
  assign w_reg_we   = w_second &  cpu_din[7];
  assign w_reg_ok   = (32'(cpu_din[5:0]) < 32'(NUM_REGS));
  assign w_addr_set = w_second & ~cpu_din[7];
  assign w_pf       = w_addr_set & ~cpu_din[6];
  assign w_a_inc    = r_addr + ADDR_W'(1);

  // Address bits above 16 KB live in a VDP register; the pointer carries into it.
  generate
    if (ADDR_W > 14) begin : g_ext
      localparam logic [ADDR_W-15:0] c_EXT_ONE = 1;
      assign w_set_addr = {r_regs[EXT_REG][ADDR_W-15:0], cpu_din[5:0], r_first};
      assign w_ext_next = {r_regs[EXT_REG][7:ADDR_W-14],
                           r_regs[EXT_REG][ADDR_W-15:0] + c_EXT_ONE};
      assign w_ext_inc  = &r_addr[13:0];
    end else begin : g_no_ext
      assign w_set_addr = {cpu_din[5:0], r_first};
      assign w_ext_next = 8'h00;
      assign w_ext_inc  = 1'b0;
    end
  endgenerate

  assign w_ext_bump = (w_start_wr | w_start_rd) & w_ext_inc;

  always_comb begin
    w_state_next = r_state;
    w_start_wr   = 1'b0;
    w_start_rd   = 1'b0;
    w_start_pf   = 1'b0;
    w_drop       = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_data_wr) begin
          w_state_next = WAIT_WR;
          w_start_wr   = 1'b1;
        end else if (w_data_rd) begin
          w_state_next = WAIT_RD;
          w_start_rd   = 1'b1;
        end else if (w_pf) begin
          w_state_next = WAIT_RD;
          w_start_pf   = 1'b1;
        end
      end
      WAIT_WR, WAIT_RD: begin
        if (vram.vram_ack) w_state_next = IDLE;
        w_drop = w_data_wr | w_data_rd | w_pf;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  assign w_fifth_take = fifth_set & (~r_5s | w_stat_rd);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= 8'h00;
      r_latch   <= 1'b0;
      r_first   <= 8'h00;
      r_addr    <= '0;
      r_buf     <= 8'h00;
      r_f       <= 1'b0;
      r_5s      <= 1'b0;
      r_c       <= 1'b0;
      r_n       <= 5'd0;
      r_overrun <= 1'b0;
      r_n_int   <= 1'b1;
      r_vaddr   <= '0;
      r_we      <= 1'b0;
      r_wdata   <= 8'h00;
    end else begin
      if (w_ctrl_wr) begin
        r_latch <= ~r_latch;
        if (!r_latch) r_first <= cpu_din;
      end else if (w_data_wr | w_data_rd | w_stat_rd) begin
        r_latch <= 1'b0;
      end

      for (int i = 0; i < NUM_REGS; i++) begin
        if (w_reg_we && w_reg_ok && cpu_din[5:0] == 6'(i)) r_regs[i] <= r_first;
        else if (w_ext_bump && i == EXT_REG)               r_regs[i] <= w_ext_next;
      end

      // Address set is honoured even while busy; only its prefetch is dropped.
      if (w_addr_set)                    r_addr <= w_set_addr;
      else if (w_start_wr | w_start_rd)  r_addr <= w_a_inc;

      if (w_start_wr) begin
        r_vaddr <= r_addr;
        r_we    <= 1'b1;
        r_wdata <= cpu_din;
      end else if (w_start_rd) begin
        r_vaddr <= w_a_inc;
        r_we    <= 1'b0;
      end else if (w_start_pf) begin
        r_vaddr <= w_set_addr;
        r_we    <= 1'b0;
      end

      if (w_start_wr)                                r_buf <= cpu_din;
      else if (r_state == WAIT_RD && vram.vram_ack)  r_buf <= vram.vram_rdata;

      r_f <= irq_set  | (r_f & ~w_stat_rd);
      r_c <= coll_set | (r_c & ~w_stat_rd);
      if (w_fifth_take) begin
        r_5s <= 1'b1;
        r_n  <= fifth_num;
      end else if (w_stat_rd) begin
        r_5s <= 1'b0;
      end

      r_overrun <= r_overrun | w_drop;
      r_n_int   <= ~(r_f & r_regs[1][5]);
    end
  end

  generate
    for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs_flat
      assign regs[g*8 +: 8] = r_regs[g];
    end
  endgenerate

  assign cpu_dout        = cpu_sel ? {r_f, r_5s, r_c, (r_5s ? r_n : 5'h1F)} : r_buf;
  assign cpu_busy        = (r_state != IDLE);
  assign overrun         = r_overrun;
  assign n_int           = r_n_int;
  assign vram.vram_req   = (r_state != IDLE);
  assign vram.vram_we    = r_we;
  assign vram.vram_addr  = r_vaddr;
  assign vram.vram_wdata = r_wdata;

endmodule

`default_nettype wire

// File: tb/tb_vdp_cpu_port.sv
// Bench for vdp_cpu_port: a 16 KB / 8-register instance and a 128 KB / 16-register
// instance share CPU stimulus; a transaction-level model predicts both.
`default_nettype none

module tb_vdp_cpu_port;

  logic clk = 1'b0;
  logic rst_n;
  logic cpu_wr, cpu_rd, cpu_sel;
  logic [7:0] cpu_din;
  logic irq_set, coll_set, fifth_set;
  logic [4:0] fifth_num;

  logic [7:0]   dout0, dout1;
  logic         busy0, busy1, ovr0, ovr1, nint0, nint1;
  logic [63:0]  regs0;
  logic [127:0] regs1;

  vdp_cpu_port_if #(.ADDR_W(14)) vif0 ();
  vdp_cpu_port_if #(.ADDR_W(17)) vif1 ();

  vdp_cpu_port #(.ADDR_W(14), .NUM_REGS(8), .EXT_REG(14)) dut0 (
    .clk(clk), .rst_n(rst_n), .cpu_wr(cpu_wr), .cpu_rd(cpu_rd), .cpu_sel(cpu_sel),
    .cpu_din(cpu_din), .cpu_dout(dout0), .cpu_busy(busy0), .overrun(ovr0), .vram(vif0),
    .irq_set(irq_set), .coll_set(coll_set), .fifth_set(fifth_set), .fifth_num(fifth_num),
    .regs(regs0), .n_int(nint0));

  vdp_cpu_port #(.ADDR_W(17), .NUM_REGS(16), .EXT_REG(14)) dut1 (
    .clk(clk), .rst_n(rst_n), .cpu_wr(cpu_wr), .cpu_rd(cpu_rd), .cpu_sel(cpu_sel),
    .cpu_din(cpu_din), .cpu_dout(dout1), .cpu_busy(busy1), .overrun(ovr1), .vram(vif1),
    .irq_set(irq_set), .coll_set(coll_set), .fifth_set(fifth_set), .fifth_num(fifth_num),
    .regs(regs1), .n_int(nint1));

  always #5 clk = ~clk;

  // VRAM responder signals
  logic        ack [2];
  logic [7:0]  rdat [2];
  logic        req [2];
  logic        we [2];
  logic [16:0] va [2];
  logic [7:0]  vwd [2];
  assign vif0.vram_ack = ack[0];
  assign vif0.vram_rdata = rdat[0];
  assign vif1.vram_ack = ack[1];
  assign vif1.vram_rdata = rdat[1];
  assign req[0] = vif0.vram_req;
  assign req[1] = vif1.vram_req;
  assign we[0]  = vif0.vram_we;
  assign we[1]  = vif1.vram_we;
  assign va[0]  = {3'b000, vif0.vram_addr};
  assign va[1]  = vif1.vram_addr;
  assign vwd[0] = vif0.vram_wdata;
  assign vwd[1] = vif1.vram_wdata;

  logic [7:0] vmem [2][131072];
  int lat;
  int cnt [2];
  int wcount [2], rcount [2], last_wa [2], last_wd [2], last_ra [2];

  int n_chk = 0;
  int n_fail = 0;

  // model state
  int m_aw [2] = '{14, 17};
  int m_nr [2] = '{8, 16};
  int m_regs [2][64];
  int m_A [2], m_B [2];
  bit m_latch;
  int m_first;
  bit mF, m5S, mC;
  int mN;

  logic [7:0] s_dout [2];
  logic       s_busy;

  initial begin
    ack[0] = 0; ack[1] = 0; rdat[0] = 0; rdat[1] = 0;
    for (int d = 0; d < 2; d++) begin
      cnt[d] = 0; wcount[d] = 0; rcount[d] = 0; last_wa[d] = 0; last_wd[d] = 0; last_ra[d] = 0;
    end
    forever begin
      @(posedge clk); #1;
      for (int d = 0; d < 2; d++) begin
        ack[d] = 1'b0;
        if (req[d] === 1'b1) begin
          if (cnt[d] >= lat) begin
            ack[d] = 1'b1;
            cnt[d] = 0;
            if (we[d]) begin
              vmem[d][va[d]] = vwd[d];
              last_wa[d] = int'(va[d]);
              last_wd[d] = int'(vwd[d]);
              wcount[d]++;
            end else begin
              rdat[d] = vmem[d][va[d]];
              last_ra[d] = int'(va[d]);
              rcount[d]++;
            end
          end else cnt[d]++;
        end else cnt[d] = 0;
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int ext_mask(int d);
    return (1 << (m_aw[d] - 14)) - 1;
  endfunction

  function automatic int set_addr(int d, int lo6);
    return (m_regs[d][14] & ext_mask(d)) * 16384 + lo6 * 256 + m_first;
  endfunction

  function automatic logic [7:0] stat_exp();
    return {mF, m5S, mC, (m5S ? 5'(mN) : 5'h1F)};
  endfunction

  task automatic m_inc(int d);
    int old = m_A[d];
    int mk = ext_mask(d);
    m_A[d] = (old + 1) % (1 << m_aw[d]);
    if (mk != 0 && (old % 16384) == 16383)
      m_regs[d][14] = (m_regs[d][14] & (255 & ~mk)) | ((m_regs[d][14] + 1) & mk);
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 64; i++) m_regs[d][i] = 0;
      m_A[d] = 0; m_B[d] = 0;
    end
    m_latch = 0; m_first = 0; mF = 0; m5S = 0; mC = 0; mN = 0;
  endtask

  task automatic check_regs();
    logic [127:0] e0, e1;
    e0 = '0; e1 = '0;
    for (int i = 0; i < 8; i++)  e0[i*8 +: 8] = 8'(m_regs[0][i]);
    for (int i = 0; i < 16; i++) e1[i*8 +: 8] = 8'(m_regs[1][i]);
    chk("regs0", {64'd0, regs0}, e0);
    chk("regs1", regs1, e1);
  endtask

  // Entered and left at 1 time unit after a rising edge.
  task automatic strobe(input bit wr, input bit sel, input logic [7:0] din);
    cpu_wr = wr; cpu_rd = !wr; cpu_sel = sel; cpu_din = din;
    #2;
    s_dout[0] = dout0; s_dout[1] = dout1; s_busy = busy0 | busy1;
    @(posedge clk); #1;
    cpu_wr = 1'b0; cpu_rd = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy0 | busy1) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("idle_timeout", {127'd0, busy0 | busy1}, 128'd0);
  endtask

  task automatic do_ctrl(input logic [7:0] din);
    int rc [2];
    bit pf = 0;
    rc[0] = rcount[0]; rc[1] = rcount[1];
    strobe(1'b1, 1'b1, din);
    if (!m_latch) begin
      m_first = int'(din); m_latch = 1;
    end else begin
      m_latch = 0;
      if (din[7]) begin
        for (int d = 0; d < 2; d++)
          if (int'(din[5:0]) < m_nr[d]) m_regs[d][din[5:0]] = m_first;
      end else begin
        for (int d = 0; d < 2; d++) m_A[d] = set_addr(d, int'(din[5:0]));
        pf = !din[6];
      end
    end
    wait_idle();
    if (pf) begin
      for (int d = 0; d < 2; d++) begin
        chk($sformatf("pf_count%0d", d), 128'(rcount[d] - rc[d]), 128'd1);
        chk($sformatf("pf_addr%0d", d), 128'(last_ra[d]), 128'(m_A[d]));
        m_B[d] = int'(vmem[d][m_A[d]]);
      end
    end
    check_regs();
  endtask

  task automatic do_wdata(input logic [7:0] din);
    int wc [2], ea [2];
    for (int d = 0; d < 2; d++) begin wc[d] = wcount[d]; ea[d] = m_A[d]; end
    strobe(1'b1, 1'b0, din);
    m_latch = 0;
    for (int d = 0; d < 2; d++) begin m_B[d] = int'(din); m_inc(d); end
    wait_idle();
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("wr_count%0d", d), 128'(wcount[d] - wc[d]), 128'd1);
      chk($sformatf("wr_addr%0d", d), 128'(last_wa[d]), 128'(ea[d]));
      chk($sformatf("wr_data%0d", d), 128'(last_wd[d]), 128'(din));
    end
    check_regs();
  endtask

  task automatic do_rdata();
    int rc [2];
    rc[0] = rcount[0]; rc[1] = rcount[1];
    strobe(1'b0, 1'b0, 8'h00);
    m_latch = 0;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("rd_dout%0d", d), 128'(s_dout[d]), 128'(m_B[d]));
      m_inc(d);
    end
    wait_idle();
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("rd_count%0d", d), 128'(rcount[d] - rc[d]), 128'd1);
      chk($sformatf("rd_addr%0d", d), 128'(last_ra[d]), 128'(m_A[d]));
      m_B[d] = int'(vmem[d][m_A[d]]);
    end
  endtask

  task automatic do_stat(input bit irq);
    logic [7:0] e;
    e = stat_exp();
    irq_set = irq;
    strobe(1'b0, 1'b1, 8'h00);
    irq_set = 1'b0;
    m_latch = 0;
    chk("stat0", 128'(s_dout[0]), 128'(e));
    chk("stat1", 128'(s_dout[1]), 128'(e));
    mF = irq; m5S = 0; mC = 0;
  endtask

  task automatic pulse(input bit irq, input bit coll, input bit fifth, input logic [4:0] num);
    irq_set = irq; coll_set = coll; fifth_set = fifth; fifth_num = num;
    @(posedge clk); #1;
    irq_set = 0; coll_set = 0; fifth_set = 0;
    mF = mF | irq; mC = mC | coll;
    if (fifth && !m5S) begin m5S = 1; mN = int'(num); end
  endtask

  initial begin
    int wc0;
    rst_n = 1'b0; cpu_wr = 0; cpu_rd = 0; cpu_sel = 0; cpu_din = 0;
    irq_set = 0; coll_set = 0; fifth_set = 0; fifth_num = 0; lat = 0;
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 131072; i++) vmem[d][i] = 8'($urandom);
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // reset state
    check_regs();
    chk("rst_nint", {nint1, nint0}, 2'b11);
    chk("rst_req", {req[1], req[0]}, 2'b00);
    chk("rst_busy", {busy1, busy0}, 2'b00);
    chk("rst_ovr", {ovr1, ovr0}, 2'b00);
    chk("rst_dout", {dout1, dout0}, 16'h0000);

    // register writes
    do_ctrl(8'h07); do_ctrl(8'h81);
    do_ctrl(8'h1F); do_ctrl(8'h87);
    chk("R1", 128'(regs0[15:8]), 128'h07);
    chk("R7", 128'(regs0[63:56]), 128'h1F);
    do_ctrl(8'h55); do_ctrl(8'h90);

    // write at top of 16 KB, wrap / carry into extension register
    do_ctrl(8'h02); do_ctrl(8'h8E);
    do_ctrl(8'hFF); do_ctrl(8'h7F);
    do_wdata(8'hAA);
    chk("wrap_wa0", 128'(last_wa[0]), 128'h3FFF);
    chk("wrap_wa1", 128'(last_wa[1]), 128'h0BFFF);
    do_wdata(8'h55);
    chk("wrap_next0", 128'(last_wa[0]), 128'h0000);
    chk("wrap_next1", 128'(last_wa[1]), 128'h0C000);
    chk("R14_carry", 128'(regs1[119:112]), 128'h03);

    // read-ahead
    do_ctrl(8'h00); do_ctrl(8'h8E);
    for (int d = 0; d < 2; d++) begin vmem[d][17'h100] = 8'h11; vmem[d][17'h101] = 8'h22; end
    do_ctrl(8'h00); do_ctrl(8'h01);
    do_rdata();
    chk("ra_first", 128'(s_dout[0]), 128'h11);
    chk("ra_pf_addr", 128'(last_ra[0]), 128'h101);
    do_rdata();
    chk("ra_second", 128'(s_dout[1]), 128'h22);

    // status and interrupt
    do_ctrl(8'h20); do_ctrl(8'h81);
    pulse(1, 0, 0, 5'd0);
    chk("nint_delay", {nint1, nint0}, 2'b11);
    @(posedge clk); #1;
    chk("nint_low", {nint1, nint0}, 2'b00);
    do_stat(0);
    chk("stat_9F", 128'(s_dout[0]), 128'h9F);
    @(posedge clk); #1;
    chk("nint_high", {nint1, nint0}, 2'b11);
    pulse(1, 0, 0, 5'd0);
    do_stat(1);
    do_stat(0);
    chk("irq_wins", 128'(s_dout[0]), 128'h9F);
    do_stat(0);
    pulse(0, 1, 1, 5'd5);
    pulse(0, 0, 1, 5'd9);
    do_stat(0);
    chk("stat_65", 128'(s_dout[1]), 128'h65);
    do_stat(0);

    // busy: second data write dropped
    lat = 5;
    wc0 = wcount[0];
    strobe(1'b1, 1'b0, 8'h33);
    m_latch = 0;
    for (int d = 0; d < 2; d++) begin m_B[d] = 8'h33; m_inc(d); end
    strobe(1'b1, 1'b0, 8'h44);
    chk("busy_seen", {127'd0, s_busy}, 128'd1);
    wait_idle();
    lat = 0;
    chk("drop_count", 128'(wcount[0] - wc0), 128'd1);
    chk("drop_data", 128'(last_wd[0]), 128'h33);
    chk("overrun", {ovr1, ovr0}, 2'b11);

    // status read resets the control-port latch
    do_ctrl(8'h34);
    do_stat(0);
    do_ctrl(8'h12); do_ctrl(8'h45);
    do_wdata(8'h99);
    chk("latch_clr", 128'(last_wa[0]), 128'h0512);

    // randomized traffic
    for (int k = 0; k < 80; k++) begin
      lat = $urandom_range(0, 3);
      case ($urandom_range(0, 4))
        0: begin do_ctrl(8'($urandom)); do_ctrl({1'b1, 1'($urandom), 6'($urandom_range(0, 17))}); end
        1: begin do_ctrl(8'($urandom)); do_ctrl({2'b01, 6'($urandom)}); end
        2: begin do_ctrl(8'($urandom)); do_ctrl({2'b00, 6'($urandom)}); end
        3: do_wdata(8'($urandom));
        default: do_rdata();
      endcase
    end

    // reset in mid-transaction
    lat = 6;
    strobe(1'b1, 1'b0, 8'hC3);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("arst_req", {req[1], req[0]}, 2'b00);
    chk("arst_busy", {busy1, busy0}, 2'b00);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    lat = 0;
    model_reset();
    @(posedge clk); #1;
    check_regs();
    chk("arst_ovr", {ovr1, ovr0}, 2'b00);
    chk("arst_nint", {nint1, nint0}, 2'b11);
    chk("arst_dout", {dout1, dout0}, 16'h0000);
    do_wdata(8'h5A);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
